// File: rtl/dcache_pkg.sv
// Shared types and helpers for the set-associative write-back data cache.
// Field widths are derived from the cache geometry so every file agrees on the address split.
package dcache_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WRITEBACK,
      ST_REFILL
   } state_t;

   function automatic int off_w_f(input int line_words);
      return $clog2(line_words) + 2;
   endfunction

   function automatic int idx_w_f(input int num_sets);
      return $clog2(num_sets);
   endfunction

   function automatic int tag_w_f(input int line_words, input int num_sets);
      return 32 - off_w_f(line_words) - idx_w_f(num_sets);
   endfunction

   // A direct-mapped cache still needs a one-bit way index to keep the arrays uniform.
   function automatic int way_w_f(input int num_ways);
      return (num_ways > 1) ? $clog2(num_ways) : 1;
   endfunction

   function automatic logic [31:0] be_merge(input logic [31:0] old_w,
                                            input logic [31:0] new_w,
                                            input logic [3:0]  be);
      logic [31:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/dcache_victim_sel.sv
// Victim way choice for a miss: lowest invalid way first, else the set's round-robin pointer.
// Purely combinational, zero latency; no flow control of its own.
module dcache_victim_sel
   import dcache_pkg::*;
#(
   parameter int NUM_WAYS = 2,
   parameter int WAY_W    = 1
) (
   input  logic [NUM_WAYS-1:0] valid_vec,
   input  logic [WAY_W-1:0]    ptr,
   output logic [WAY_W-1:0]    victim,
   output logic                victim_valid
);

   // Scanning from the top lets the lowest invalid way overwrite earlier picks.
   always_comb begin
      victim       = ptr;
      victim_valid = 1'b1;
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         if (!valid_vec[w]) begin
            victim       = WAY_W'(w);
            victim_valid = 1'b0;
         end
      end
   end

endmodule

// File: rtl/dcache_wb_sa.sv
// N-way write-back, write-allocate data cache; hits complete in the request cycle.
// Any miss stalls the pipeline through dirty-victim writeback and line refill, one word per mem_ready.
module dcache_wb_sa
   import dcache_pkg::*;
#(
   parameter int NUM_WAYS   = 2,
   parameter int NUM_SETS   = 128,
   parameter int LINE_WORDS = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_read,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic [31:0] rsp_rdata,
   output logic        stall,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready
);

   localparam int OFF_W = off_w_f(LINE_WORDS);
   localparam int IDX_W = idx_w_f(NUM_SETS);
   localparam int TAG_W = tag_w_f(LINE_WORDS, NUM_SETS);
   localparam int WAY_W = way_w_f(NUM_WAYS);
   localparam int CNT_W = $clog2(LINE_WORDS);

   logic [31:0]         data_q  [NUM_WAYS][NUM_SETS][LINE_WORDS];
   logic [TAG_W-1:0]    tag_q   [NUM_WAYS][NUM_SETS];
   logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
   logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
   logic [WAY_W-1:0]    ptr_q   [NUM_SETS];

   state_t              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [TAG_W-1:0]    miss_tag_q;
   logic [IDX_W-1:0]    miss_idx_q;
   logic [WAY_W-1:0]    vic_way_q;
   logic [TAG_W-1:0]    vic_tag_q;

   logic [CNT_W-1:0]    req_off;
   logic [IDX_W-1:0]    req_idx;
   logic [TAG_W-1:0]    req_tag;
   logic                unused_addr_lsb;

   logic                hit;
   logic [WAY_W-1:0]    hit_way;
   logic [31:0]         hit_word;
   logic                miss;
   logic [WAY_W-1:0]    victim;
   logic                victim_valid;
   logic                last_word;
   logic [CNT_W-1:0]    cnt_nxt;

   assign req_off         = req_addr[OFF_W-1:2];
   assign req_idx         = req_addr[OFF_W+IDX_W-1:OFF_W];
   assign req_tag         = req_addr[31:OFF_W+IDX_W];
   assign unused_addr_lsb = ^req_addr[1:0];

   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         if (valid_q[req_idx][w] && (tag_q[w][req_idx] == req_tag)) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
      end
   end

   assign hit_word  = data_q[hit_way][req_idx][req_off];
   assign miss      = (req_read || req_write) && !hit;
   assign stall     = (state_q != ST_IDLE) || miss;
   assign rsp_rdata = (state_q == ST_IDLE && req_read && hit) ? hit_word : 32'h0;
   assign last_word = (cnt_q == CNT_W'(LINE_WORDS - 1));
   assign cnt_nxt   = cnt_q + 1'b1;

   dcache_victim_sel #(
      .NUM_WAYS (NUM_WAYS),
      .WAY_W    (WAY_W)
   ) u_victim_sel (
      .valid_vec    (valid_q[req_idx]),
      .ptr          (ptr_q[req_idx]),
      .victim       (victim),
      .victim_valid (victim_valid)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         miss_tag_q <= '0;
         miss_idx_q <= '0;
         vic_way_q  <= '0;
         vic_tag_q  <= '0;
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         mem_addr   <= 32'h0;
         mem_wdata  <= 32'h0;
         for (int s = 0; s < NUM_SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
            ptr_q[s]   <= '0;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_write && hit) begin
                  dirty_q[req_idx][hit_way] <= 1'b1;
               end else if (miss) begin
                  miss_tag_q <= req_tag;
                  miss_idx_q <= req_idx;
                  vic_way_q  <= victim;
                  vic_tag_q  <= tag_q[victim][req_idx];
                  cnt_q      <= '0;
                  if (victim_valid && dirty_q[req_idx][victim]) begin
                     state_q   <= ST_WRITEBACK;
                     mem_write <= 1'b1;
                     mem_addr  <= {tag_q[victim][req_idx], req_idx, {CNT_W{1'b0}}, 2'b00};
                     mem_wdata <= data_q[victim][req_idx][0];
                  end else begin
                     state_q  <= ST_REFILL;
                     mem_read <= 1'b1;
                     mem_addr <= {req_tag, req_idx, {CNT_W{1'b0}}, 2'b00};
                  end
               end
            end
            ST_WRITEBACK: begin
               if (mem_ready) begin
                  if (last_word) begin
                     cnt_q     <= '0;
                     state_q   <= ST_REFILL;
                     mem_write <= 1'b0;
                     mem_wdata <= 32'h0;
                     mem_read  <= 1'b1;
                     mem_addr  <= {miss_tag_q, miss_idx_q, {CNT_W{1'b0}}, 2'b00};
                  end else begin
                     cnt_q     <= cnt_nxt;
                     mem_addr  <= {vic_tag_q, miss_idx_q, cnt_nxt, 2'b00};
                     mem_wdata <= data_q[vic_way_q][miss_idx_q][cnt_nxt];
                  end
               end
            end
            ST_REFILL: begin
               if (mem_ready) begin
                  if (last_word) begin
                     cnt_q                           <= '0;
                     state_q                         <= ST_IDLE;
                     mem_read                        <= 1'b0;
                     mem_addr                        <= 32'h0;
                     valid_q[miss_idx_q][vic_way_q]  <= 1'b1;
                     dirty_q[miss_idx_q][vic_way_q]  <= 1'b0;
                     ptr_q[miss_idx_q] <= (ptr_q[miss_idx_q] == WAY_W'(NUM_WAYS - 1))
                                          ? '0 : ptr_q[miss_idx_q] + 1'b1;
                  end else begin
                     cnt_q    <= cnt_nxt;
                     mem_addr <= {miss_tag_q, miss_idx_q, cnt_nxt, 2'b00};
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Data and tag arrays carry no reset; valid bits alone decide whether their contents count.
   always_ff @(posedge clk) begin
      if (state_q == ST_IDLE && req_write && hit) begin
         data_q[hit_way][req_idx][req_off] <= be_merge(hit_word, req_wdata, req_be);
      end
      if (state_q == ST_REFILL && mem_ready) begin
         data_q[vic_way_q][miss_idx_q][cnt_q] <= mem_rdata;
         if (last_word) tag_q[vic_way_q][miss_idx_q] <= miss_tag_q;
      end
   end

endmodule
